pwm_cfg_ctrl: RTL and testbench

Sequencing and configuration controller for the PWM up/down counter. It owns the counter's period, prescale, direction, enable and synchronous-reset inputs. Software-side config writes enter through a valid/ready handshake and are held in shadow registers. They are applied glitch-free at the counter's wrap boundary, or immediately when a restart is requested.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_wrap_detect.sv | 44 ++++
 rtl/pwm_cfg_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_cfg_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM configuration controller.
//   state_t   - controller sequencing states
//   CNT_W_DEF - default counter/period width
//   PS_W_DEF  - default prescale width
//   cfg_t     - one software config write (period, prescale, direction, restart)
package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PS_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    PEND,
    APPLY
  } state_t;

  // Field widths follow the default constants; the controller's CNT_W/PS_W
  // parameters are expected to match them.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [PS_W_DEF-1:0]  prescale;
    logic                 upnotdown;
    logic                 restart;
  } cfg_t;

endpackage

// File: rtl/pwm_wrap_detect.sv
// pwm_wrap_detect: flags the cycle in which the PWM counter has just wrapped.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   count_val  - live counter value
//   period     - period currently driven to the counter
//   upnotdown  - direction currently driven to the counter (1 = up)
//   wrap       - high in the cycle right after the counter wrapped
module pwm_wrap_detect
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_val,
  input  logic [CNT_W-1:0] period,
  input  logic             upnotdown,
  output logic             wrap
);

  logic [CNT_W-1:0] prev_cnt;

  // Last cycle's counter value, so a wrap is seen as a pair of samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cnt <= '0;
    end else begin
      prev_cnt <= count_val;
    end
  end

  // A zero period never shows a distinct wrap pair, so every cycle counts.
  always_comb begin
    wrap = 1'b0;
    if (period == '0) begin
      wrap = 1'b1;
    end else if (upnotdown) begin
      wrap = (prev_cnt == period) && (count_val == '0);
    end else begin
      wrap = (prev_cnt == '0) && (count_val == period);
    end
  end

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// pwm_cfg_ctrl: sequencing/config controller for the PWM up/down counter.
// Config writes arrive on a valid/ready handshake, are held in a shadow
// register and reach the counter outputs at a counter wrap, or at once when
// a restart is requested or the counter is idle.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start, stop              - one-cycle run control pulses
//   cfg_valid / cfg_ready    - config write handshake
//   cfg_period/_prescale/_upnotdown/_restart - config write fields
//   count_val                - live counter value
//   period, prescale, upnotdown, en, count_reset - registered counter controls
//   update_done              - one-cycle pulse when new config reaches outputs
//   running                  - high whenever not IDLE
module pwm_cfg_ctrl
  import pwm_pkg::*;
#(
  parameter int               CNT_W         = CNT_W_DEF,
  parameter int               PS_W          = PS_W_DEF,
  parameter logic [CNT_W-1:0] RST_PERIOD    = 16'd999,
  parameter logic [PS_W-1:0]  RST_PRESCALE  = 8'd0,
  parameter logic             RST_UPNOTDOWN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [PS_W-1:0]  cfg_prescale,
  input  logic             cfg_upnotdown,
  input  logic             cfg_restart,
  input  logic [CNT_W-1:0] count_val,
  output logic [CNT_W-1:0] period,
  output logic [PS_W-1:0]  prescale,
  output logic             upnotdown,
  output logic             en,
  output logic             count_reset,
  output logic             update_done,
  output logic             running
);

  localparam cfg_t RST_CFG = '{
    period:    RST_PERIOD,
    prescale:  RST_PRESCALE,
    upnotdown: RST_UPNOTDOWN,
    restart:   1'b0
  };

  state_t state, state_nxt;
  logic   apply_run, apply_run_nxt;
  logic   transfer;
  logic   wrap;
  cfg_t   incoming, shadow, load_cfg;
  logic   en_nxt, count_reset_nxt, ready_nxt, running_nxt;

  assign transfer = cfg_valid && cfg_ready;

  assign incoming = '{
    period:    cfg_period,
    prescale:  cfg_prescale,
    upnotdown: cfg_upnotdown,
    restart:   cfg_restart
  };

  // An accepted write goes to APPLY in the same cycle it lands in the shadow,
  // so take the fields straight from the bus to save a cycle of latency.
  assign load_cfg = transfer ? incoming : shadow;

  pwm_wrap_detect #(
    .CNT_W(CNT_W)
  ) u_wrap (
    .clk      (clk),
    .rst      (rst),
    .count_val(count_val),
    .period   (period),
    .upnotdown(upnotdown),
    .wrap     (wrap)
  );

  // State register plus the "return to RUN after APPLY" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      apply_run <= 1'b0;
    end else begin
      state     <= state_nxt;
      apply_run <= apply_run_nxt;
    end
  end

  // Next state. stop always wins, but an accepted write is never dropped:
  // it still passes through APPLY, which then lands in IDLE.
  always_comb begin
    state_nxt     = state;
    apply_run_nxt = apply_run;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_nxt     = APPLY;
          apply_run_nxt = 1'b0;
        end else if (start && !stop) begin
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = stop ? IDLE : RUN;
      end
      RUN: begin
        if (transfer) begin
          if (stop) begin
            state_nxt     = APPLY;
            apply_run_nxt = 1'b0;
          end else if (cfg_restart) begin
            state_nxt     = APPLY;
            apply_run_nxt = 1'b1;
          end else begin
            state_nxt = PEND;
          end
        end else if (stop) begin
          state_nxt = IDLE;
        end
      end
      PEND: begin
        if (stop) begin
          state_nxt     = APPLY;
          apply_run_nxt = 1'b0;
        end else if (wrap) begin
          state_nxt     = APPLY;
          apply_run_nxt = 1'b1;
        end
      end
      APPLY: begin
        state_nxt     = (apply_run && !stop) ? RUN : IDLE;
        apply_run_nxt = 1'b0;
      end
      default: begin
        state_nxt     = IDLE;
        apply_run_nxt = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the state being entered and then registered,
  // so they line up with the state they belong to.
  always_comb begin
    en_nxt          = 1'b0;
    count_reset_nxt = 1'b0;
    ready_nxt       = 1'b0;
    running_nxt     = 1'b1;
    case (state_nxt)
      IDLE: begin
        ready_nxt   = 1'b1;
        running_nxt = 1'b0;
      end
      START: begin
        en_nxt          = 1'b1;
        count_reset_nxt = 1'b1;
      end
      RUN: begin
        en_nxt    = 1'b1;
        ready_nxt = 1'b1;
      end
      PEND: begin
        en_nxt = 1'b1;
      end
      APPLY: begin
        en_nxt          = apply_run_nxt;
        count_reset_nxt = apply_run_nxt;
      end
      default: begin
        running_nxt = 1'b0;
      end
    endcase
  end

  // Counter-facing output registers; config fields only change on APPLY entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period      <= RST_PERIOD;
      prescale    <= RST_PRESCALE;
      upnotdown   <= RST_UPNOTDOWN;
      en          <= 1'b0;
      count_reset <= 1'b0;
      update_done <= 1'b0;
      running     <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      en          <= en_nxt;
      count_reset <= count_reset_nxt;
      update_done <= (state_nxt == APPLY);
      running     <= running_nxt;
      cfg_ready   <= ready_nxt;
      if (state_nxt == APPLY) begin
        period    <= load_cfg.period;
        prescale  <= load_cfg.prescale;
        upnotdown <= load_cfg.upnotdown;
      end
    end
  end

  // Shadow copy of the last accepted write, held until a wrap applies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= RST_CFG;
    end else if (transfer) begin
      shadow <= incoming;
    end
  end

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// tb_pwm_cfg_ctrl: self-checking bench for pwm_cfg_ctrl. A vector table
// drives the handshake/FSM paths with a fixed count_val; hand-written
// sequences then run a behavioural counter to exercise wrap-timed updates.
module tb_pwm_cfg_ctrl;

  typedef struct packed {
    logic [15:0] period;
    logic [7:0]  prescale;
    logic        upnotdown;
    logic        en;
    logic        count_reset;
    logic        update_done;
    logic        running;
    logic        cfg_ready;
  } outs_t;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic        valid;
    logic [15:0] cp;
    logic [7:0]  cps;
    logic        cud;
    logic        crs;
    logic [15:0] cnt;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, cfg_valid, cfg_ready;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_prescale;
  logic        cfg_upnotdown, cfg_restart;
  logic [15:0] count_val;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        upnotdown, en, count_reset, update_done, running;

  logic        use_model;
  logic [15:0] tbl_cnt;
  logic [15:0] model_cnt;
  logic [7:0]  ps_cnt;

  int    nChecks = 0;
  int    nErrors = 0;
  outs_t sbq[$];
  outs_t act;
  vec_t  vecs[19];

  assign count_val = use_model ? model_cnt : tbl_cnt;
  assign act = {period, prescale, upnotdown, en, count_reset, update_done, running, cfg_ready};

  always #5 clk = ~clk;

  pwm_cfg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_upnotdown(cfg_upnotdown),
    .cfg_restart  (cfg_restart),
    .count_val    (count_val),
    .period       (period),
    .prescale     (prescale),
    .upnotdown    (upnotdown),
    .en           (en),
    .count_reset  (count_reset),
    .update_done  (update_done),
    .running      (running)
  );

  // Behavioural up/down counter obeying the controller's outputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_cnt <= '0;
      ps_cnt    <= '0;
    end else if (count_reset) begin
      model_cnt <= '0;
      ps_cnt    <= '0;
    end else if (en) begin
      if (ps_cnt >= prescale) begin
        ps_cnt <= '0;
        if (upnotdown) model_cnt <= (model_cnt >= period) ? 16'd0 : model_cnt + 16'd1;
        else           model_cnt <= (model_cnt == 16'd0) ? period : model_cnt - 16'd1;
      end else begin
        ps_cnt <= ps_cnt + 8'd1;
      end
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic outs_t mko(input logic [15:0] p, input logic [7:0] ps, input logic ud,
                                input logic e, input logic cr, input logic dn,
                                input logic rn, input logic rdy);
    mko = {p, ps, ud, e, cr, dn, rn, rdy};
  endfunction

  function automatic vec_t mkv(input logic st, input logic sp, input logic v,
                               input logic [15:0] p, input logic [7:0] ps, input logic ud,
                               input logic rs, input logic [15:0] c, input outs_t e);
    mkv = {st, sp, v, p, ps, ud, rs, c, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] req);
    nChecks++;
    if (actual !== req) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, req);
    end
  endtask

  // Drive one vector and queue the outputs expected after the next edge.
  task automatic applyStimulus(input vec_t v);
    start         = v.start;
    stop          = v.stop;
    cfg_valid     = v.valid;
    cfg_period    = v.cp;
    cfg_prescale  = v.cps;
    cfg_upnotdown = v.cud;
    cfg_restart   = v.crs;
    tbl_cnt       = v.cnt;
    sbq.push_back(v.exp);
  endtask

  task automatic checkOutput(input string name);
    outs_t e;
    if (sbq.size() == 0) begin
      check({name, " sb-empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check(name, {2'b0, act}, {2'b0, e});
    end
  endtask

  task automatic quiet();
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic cfgWrite(input logic [15:0] p, input logic [7:0] ps, input logic ud, input logic rs);
    cfg_valid     = 1'b1;
    cfg_period    = p;
    cfg_prescale  = ps;
    cfg_upnotdown = ud;
    cfg_restart   = rs;
  endtask

  task automatic waitCnt(input logic [15:0] target, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (count_val == target) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check(name, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    int doneSeen;
    logic periodStuck;

    rst = 1'b1;
    use_model = 1'b0;
    tbl_cnt = '0;
    quiet();
    cfg_period = '0;
    cfg_prescale = '0;
    cfg_upnotdown = 1'b0;
    cfg_restart = 1'b0;

    // Columns: start stop valid | period ps ud restart | count_val | expected outputs
    vecs[0]  = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd999,8'd0,1, 0,0,0,0,1));
    vecs[1]  = mkv(1,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd999,8'd0,1, 1,1,0,1,0));
    vecs[2]  = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd999,8'd0,1, 1,0,0,1,1));
    vecs[3]  = mkv(1,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd999,8'd0,1, 1,0,0,1,1));
    vecs[4]  = mkv(0,0,1, 16'd20,8'd2,0,1, 16'd5 , mko(16'd20 ,8'd2,0, 1,1,1,1,0));
    vecs[5]  = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd5 , mko(16'd20 ,8'd2,0, 1,0,0,1,1));
    vecs[6]  = mkv(0,0,1, 16'd30,8'd0,1,0, 16'd10, mko(16'd20 ,8'd2,0, 1,0,0,1,0));
    vecs[7]  = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd9 , mko(16'd20 ,8'd2,0, 1,0,0,1,0));
    vecs[8]  = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd20 ,8'd2,0, 1,0,0,1,0));
    vecs[9]  = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd20, mko(16'd30 ,8'd0,1, 1,1,1,1,0));
    vecs[10] = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd30 ,8'd0,1, 1,0,0,1,1));
    vecs[11] = mkv(1,1,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd30 ,8'd0,1, 0,0,0,0,1));
    vecs[12] = mkv(1,1,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd30 ,8'd0,1, 0,0,0,0,1));
    vecs[13] = mkv(1,0,1, 16'd7 ,8'd3,0,0, 16'd0 , mko(16'd7  ,8'd3,0, 0,0,1,1,0));
    vecs[14] = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd7  ,8'd3,0, 0,0,0,0,1));
    vecs[15] = mkv(1,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd7  ,8'd3,0, 1,1,0,1,0));
    vecs[16] = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd7  ,8'd3,0, 1,0,0,1,1));
    vecs[17] = mkv(0,1,1, 16'd12,8'd1,1,1, 16'd0 , mko(16'd12 ,8'd1,1, 0,0,1,1,0));
    vecs[18] = mkv(0,0,0, 16'd0 ,8'd0,0,0, 16'd0 , mko(16'd12 ,8'd1,1, 0,0,0,0,1));

    step();
    step();
    check("reset outputs", {2'b0, act}, {2'b0, mko(16'd999,8'd0,1, 0,0,0,0,1)});
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i));
    end
    quiet();

    // Fresh reset, then the counter model takes over count_val.
    rst = 1'b1;
    step();
    rst = 1'b0;
    use_model = 1'b1;

    // Start pulse: count_reset for exactly one cycle, en held afterwards.
    start = 1'b1;
    step();
    start = 1'b0;
    check("A start cr", {31'b0, count_reset}, 32'd1);
    check("A start en", {31'b0, en}, 32'd1);
    check("A start period", {16'b0, period}, 32'd999);
    step();
    check("A run cr", {31'b0, count_reset}, 32'd0);
    check("A run en", {31'b0, en}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("A stop en", {31'b0, en}, 32'd0);

    // Period 9 up, then a deferred write of period 4 applied at the 9->0 wrap.
    cfgWrite(16'd9, 8'd0, 1'b1, 1'b0);
    step();
    quiet();
    check("B idle apply period", {16'b0, period}, 32'd9);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    waitCnt(16'd3, "B reach 3");
    check("B ready in run", {31'b0, cfg_ready}, 32'd1);
    cfgWrite(16'd4, 8'd0, 1'b1, 1'b0);
    step();
    quiet();
    check("B pend ready", {31'b0, cfg_ready}, 32'd0);
    check("B pend period", {16'b0, period}, 32'd9);
    waitCnt(16'd9, "B reach 9");
    step();
    check("B wrap cnt", {16'b0, count_val}, 32'd0);
    check("B wrap period held", {16'b0, period}, 32'd9);
    step();
    check("B apply period", {16'b0, period}, 32'd4);
    check("B apply cr", {31'b0, count_reset}, 32'd1);
    check("B apply done", {31'b0, update_done}, 32'd1);
    step();
    check("B after done", {31'b0, update_done}, 32'd0);
    check("B after cr", {31'b0, count_reset}, 32'd0);
    check("B restart cnt", {16'b0, count_val}, 32'd0);
    waitCnt(16'd4, "B reach 4");
    step();
    check("B wraps at 4", {16'b0, count_val}, 32'd0);

    // Period 9 down via restart, then a restart write of period 5 up.
    cfgWrite(16'd9, 8'd0, 1'b0, 1'b1);
    step();
    quiet();
    step();
    step();
    check("C down wrap", {16'b0, count_val}, 32'd9);
    step();
    cfgWrite(16'd5, 8'd0, 1'b1, 1'b1);
    step();
    quiet();
    check("C restart outputs", {2'b0, act}, {2'b0, mko(16'd5,8'd0,1, 1,1,1,1,0)});
    step();
    check("C restart cnt", {16'b0, count_val}, 32'd0);
    check("C run outputs", {2'b0, act}, {2'b0, mko(16'd5,8'd0,1, 1,0,0,1,1)});
    waitCnt(16'd5, "C reach 5");
    step();
    check("C wraps at 5", {16'b0, count_val}, 32'd0);

    // Pending write flushed by stop before any wrap.
    cfgWrite(16'd9, 8'd0, 1'b1, 1'b1);
    step();
    quiet();
    step();
    waitCnt(16'd2, "D reach 2");
    cfgWrite(16'd6, 8'd0, 1'b1, 1'b0);
    step();
    quiet();
    check("D pend outputs", {2'b0, act}, {2'b0, mko(16'd9,8'd0,1, 1,0,0,1,0)});
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("D stop apply", {2'b0, act}, {2'b0, mko(16'd6,8'd0,1, 0,0,1,1,0)});
    step();
    check("D idle", {2'b0, act}, {2'b0, mko(16'd6,8'd0,1, 0,0,0,0,1)});

    // Zero period: every pending cycle counts as a wrap.
    cfgWrite(16'd0, 8'd0, 1'b1, 1'b0);
    step();
    quiet();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cfgWrite(16'd0, 8'd1, 1'b1, 1'b0);
    step();
    quiet();
    check("E pend", {2'b0, act}, {2'b0, mko(16'd0,8'd0,1, 1,0,0,1,0)});
    step();
    check("E apply", {2'b0, act}, {2'b0, mko(16'd0,8'd1,1, 1,1,1,1,0)});
    step();
    cfgWrite(16'd3, 8'd0, 1'b1, 1'b0);
    step();
    quiet();
    check("E pend2 ready", {31'b0, cfg_ready}, 32'd0);
    step();
    check("E apply2", {2'b0, act}, {2'b0, mko(16'd3,8'd0,1, 1,1,1,1,0)});
    step();

    // Reset while a period-7 write is pending.
    waitCnt(16'd1, "F reach 1");
    cfgWrite(16'd7, 8'd0, 1'b1, 1'b0);
    step();
    quiet();
    check("F pend ready", {31'b0, cfg_ready}, 32'd0);
    rst = 1'b1;
    #2;
    check("F async reset", {2'b0, act}, {2'b0, mko(16'd999,8'd0,1, 0,0,0,0,1)});
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("F start period", {16'b0, period}, 32'd999);
    doneSeen = 0;
    periodStuck = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (update_done) doneSeen++;
      if (period != 16'd999) periodStuck = 1'b0;
    end
    check("F no stale apply", doneSeen, 32'd0);
    check("F period held 999", {31'b0, periodStuck}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
